// File: rtl/traffic_ctrl_np_pkg.sv
// traffic_pkg: shared types, lamp encodings and the round-robin phase
// selector for the N-direction traffic controller.
//   state_e     : controller state (GREEN, YELLOW, ALL_RED, FLASH)
//   LAMP_*      : per-direction {R,Y,G} lamp codes
//   next_phase  : next phase after all-red, optionally skipping idle phases
package traffic_pkg;

  typedef enum logic [1:0] {
    GREEN   = 2'd0,
    YELLOW  = 2'd1,
    ALL_RED = 2'd2,
    FLASH   = 2'd3
  } state_e;

  localparam logic [2:0] LAMP_G   = 3'b001;
  localparam logic [2:0] LAMP_Y   = 3'b010;
  localparam logic [2:0] LAMP_R   = 3'b100;
  localparam logic [2:0] LAMP_OFF = 3'b000;

  // Sized for the largest supported controller (4 directions). The scan
  // starts at cur+1 and wraps, so the phase just served is considered last.
  // With skipping off, or no demand at all, it is plain round-robin.
  function automatic logic [1:0] next_phase(input logic [3:0] dem,
                                            input logic [1:0] cur,
                                            input logic       skip_en,
                                            input int         num_dir);
    logic [1:0] nxt;
    logic       found;
    int         idx;
    nxt   = 2'((int'(cur) + 1) % num_dir);
    found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = (int'(cur) + k) % num_dir;
      if (skip_en && !found && (k <= num_dir) && dem[2'(idx)]) begin
        nxt   = 2'(idx);
        found = 1'b1;
      end
    end
    return nxt;
  endfunction

endpackage

// File: rtl/traffic_ctrl_np_if.sv
// Signal bundle between the intersection logic and the traffic controller.
//   req, preempt, preempt_dir, flash         : requests into the controller
//   lights, cur_phase, preempt_ack, in_flash : controller status / lamp drive
// master = request side, slave = controller side.
interface traffic_ctrl_np_if #(
  parameter int NUM_DIR = 2
);
  localparam int PW = $clog2(NUM_DIR);

  logic [NUM_DIR-1:0]   req;
  logic                 preempt;
  logic [PW-1:0]        preempt_dir;
  logic                 flash;
  logic [3*NUM_DIR-1:0] lights;
  logic [PW-1:0]        cur_phase;
  logic                 preempt_ack;
  logic                 in_flash;

  modport master (
    output req, preempt, preempt_dir, flash,
    input  lights, cur_phase, preempt_ack, in_flash
  );

  modport slave (
    input  req, preempt, preempt_dir, flash,
    output lights, cur_phase, preempt_ack, in_flash
  );

endinterface

// File: rtl/traffic_ctrl_np_phase_timer.sv
// phase_timer: per-state dwell counter for the traffic controller.
//   clk, rst : clock, asynchronous active-low reset
//   clr      : restart from zero (state entry / flash toggle)
//   hold     : freeze once the count reaches dur-1 (preemption hold)
//   dur      : duration of the current state in cycles (>= 1)
//   cnt      : current count
//   done     : cnt == dur-1, i.e. this is the last cycle of the state
module phase_timer #(
  parameter int TW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          hold,
  input  logic [TW-1:0] dur,
  output logic [TW-1:0] cnt,
  output logic          done
);

  logic [TW-1:0] cnt_q, cnt_d;

  assign done = (cnt_q == dur - TW'(1));
  assign cnt  = cnt_q;

  // The owner clears on every done outside a hold, so the count never wraps.
  always_comb begin
    if (clr)              cnt_d = '0;
    else if (hold && done) cnt_d = cnt_q;
    else                  cnt_d = cnt_q + TW'(1);
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/traffic_ctrl_np.sv
// traffic_ctrl_np: N-direction traffic-light controller.
// Round-robin GREEN -> YELLOW -> ALL_RED per phase, with demand-based phase
// skipping, emergency preemption (minimum green protected) and a maintenance
// flash mode entered at the next all-red.
//   clk  : clock
//   rst  : asynchronous active-low reset (lamps go all-red immediately)
//   bus  : traffic_ctrl_np_if.slave -- req/preempt/preempt_dir/flash in,
//          lights/cur_phase/preempt_ack/in_flash out
module traffic_ctrl_np
  import traffic_pkg::*;
#(
  parameter int NUM_DIR   = 2,
  parameter int TW        = 16,
  parameter int GREEN_T   = 10000,
  parameter int YELLOW_T  = 1500,
  parameter int ALLRED_T  = 200,
  parameter int MIN_GREEN = 1000,
  parameter int FLASH_T   = 500,
  parameter int SKIP_EN   = 1
) (
  input  logic             clk,
  input  logic             rst,
  traffic_ctrl_np_if.slave bus
);

  localparam int PW = $clog2(NUM_DIR);
  localparam logic [PW-1:0] LAST_PHASE = PW'(NUM_DIR - 1);
  localparam logic [TW-1:0] MIN_G_LAST = TW'(MIN_GREEN - 1);

  state_e               state_q, state_d;
  logic [PW-1:0]        cur_phase_q, cur_phase_d;
  logic [NUM_DIR-1:0]   dem_q, dem_d;
  logic                 flash_lat_q, flash_lat_d;
  logic                 lit_q, lit_d;

  logic [TW-1:0]        t_cnt, tmr_dur;
  logic                 tmr_clr, tmr_hold, tmr_done;
  logic                 pre_valid, pre_hold, pre_cut;
  logic [3*NUM_DIR-1:0] lamps;

  phase_timer #(.TW(TW)) u_timer (
    .clk  (clk),
    .rst  (rst),
    .clr  (tmr_clr),
    .hold (tmr_hold),
    .dur  (tmr_dur),
    .cnt  (t_cnt),
    .done (tmr_done)
  );

  always_comb begin
    case (state_q)
      GREEN:   tmr_dur = TW'(GREEN_T);
      YELLOW:  tmr_dur = TW'(YELLOW_T);
      FLASH:   tmr_dur = TW'(FLASH_T);
      default: tmr_dur = TW'(ALLRED_T);
    endcase
  end

  // An out-of-range preempt_dir is treated as no preemption at all.
  assign pre_valid = bus.preempt && (int'(bus.preempt_dir) < NUM_DIR);
  assign pre_hold  = pre_valid && (bus.preempt_dir == cur_phase_q);
  assign pre_cut   = pre_valid && (bus.preempt_dir != cur_phase_q) && (t_cnt >= MIN_G_LAST);

  // NOTE: every variable gets a default at the top of the block, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    cur_phase_d = cur_phase_q;
    dem_d       = dem_q | bus.req;
    flash_lat_d = flash_lat_q | bus.flash;
    lit_d       = lit_q;
    tmr_clr     = 1'b0;
    tmr_hold    = 1'b0;

    // In flash, preemption cannot take the signals, so it is remembered as
    // ordinary demand for the preempt direction.
    if ((state_q == FLASH) && pre_valid) dem_d[bus.preempt_dir] = 1'b1;

    case (state_q)
      GREEN: begin
        tmr_hold = pre_hold;
        if ((tmr_done && !pre_hold) || pre_cut) begin
          state_d = YELLOW;
          tmr_clr = 1'b1;
        end
      end
      YELLOW: begin
        if (tmr_done) begin
          state_d = ALL_RED;
          tmr_clr = 1'b1;
        end
      end
      ALL_RED: begin
        if (tmr_done) begin
          tmr_clr = 1'b1;
          if (flash_lat_q) begin
            state_d = FLASH;
            lit_d   = 1'b1;
          end else begin
            state_d = GREEN;
            if (pre_valid) cur_phase_d = bus.preempt_dir;
            else cur_phase_d = PW'(next_phase(4'(dem_q), 2'(cur_phase_q),
                                              SKIP_EN != 0, NUM_DIR));
            // Entering phase is served now; this clear overrides a same-cycle req.
            dem_d[cur_phase_d] = 1'b0;
          end
        end
      end
      FLASH: begin
        if (!bus.flash) begin
          // Restart the cycle so phase 0 is the first one served.
          state_d     = ALL_RED;
          cur_phase_d = LAST_PHASE;
          flash_lat_d = 1'b0;
          tmr_clr     = 1'b1;
        end else if (tmr_done) begin
          lit_d   = !lit_q;
          tmr_clr = 1'b1;
        end
      end
      default: begin
        state_d     = ALL_RED;
        cur_phase_d = LAST_PHASE;
        tmr_clr     = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ALL_RED;
      cur_phase_q <= LAST_PHASE;
      dem_q       <= '0;
      flash_lat_q <= 1'b0;
      lit_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_phase_q <= cur_phase_d;
      dem_q       <= dem_d;
      flash_lat_q <= flash_lat_d;
      lit_q       <= lit_d;
    end
  end

  // Lamps decode straight from state flops, so the async reset forces
  // all-red without waiting for a clock.
  always_comb begin
    lamps = '0;
    for (int d = 0; d < NUM_DIR; d++) begin
      case (state_q)
        GREEN:   lamps[3*d +: 3] = (cur_phase_q == PW'(d)) ? LAMP_G : LAMP_R;
        YELLOW:  lamps[3*d +: 3] = (cur_phase_q == PW'(d)) ? LAMP_Y : LAMP_R;
        FLASH:   lamps[3*d +: 3] = !lit_q ? LAMP_OFF : ((d == 0) ? LAMP_Y : LAMP_R);
        default: lamps[3*d +: 3] = LAMP_R;
      endcase
    end
  end

  assign bus.lights      = lamps;
  assign bus.cur_phase   = cur_phase_q;
  assign bus.preempt_ack = (state_q == GREEN) && bus.preempt && (bus.preempt_dir == cur_phase_q);
  assign bus.in_flash    = (state_q == FLASH);

endmodule

// File: tb/tb_traffic_ctrl_np.sv
// Self-checking bench for traffic_ctrl_np.
// Three instances share clk/rst: A (2 dirs, fixed cycle), B (4 dirs, phase
// skipping), C (3 dirs, fixed cycle, so preempt_dir=3 is an out-of-range
// value). Stimulus pushes the hand-computed outputs of every cycle into a
// scoreboard queue; a monitor pops one entry per falling edge and compares.
module tb_traffic_ctrl_np;

  localparam logic [2:0] LG = 3'b001;
  localparam logic [2:0] LY = 3'b010;
  localparam logic [2:0] LR = 3'b100;
  localparam logic [2:0] LO = 3'b000;

  localparam int DA = 0;
  localparam int DB = 1;
  localparam int DC = 2;

  typedef struct {
    int          dut;
    int          tag;
    logic [11:0] lights;
    logic [1:0]  phase;
    logic        ack;
    logic        fl;
  } exp_t;

  logic clk;
  logic rst;
  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  traffic_ctrl_np_if #(.NUM_DIR(2)) ifa ();
  traffic_ctrl_np_if #(.NUM_DIR(4)) ifb ();
  traffic_ctrl_np_if #(.NUM_DIR(3)) ifc ();

  traffic_ctrl_np #(.NUM_DIR(2), .TW(16), .GREEN_T(8), .YELLOW_T(3), .ALLRED_T(2),
                    .MIN_GREEN(4), .FLASH_T(2), .SKIP_EN(0))
    u_dut_a (.clk(clk), .rst(rst), .bus(ifa));

  traffic_ctrl_np #(.NUM_DIR(4), .TW(16), .GREEN_T(8), .YELLOW_T(3), .ALLRED_T(2),
                    .MIN_GREEN(4), .FLASH_T(2), .SKIP_EN(1))
    u_dut_b (.clk(clk), .rst(rst), .bus(ifb));

  traffic_ctrl_np #(.NUM_DIR(3), .TW(16), .GREEN_T(8), .YELLOW_T(3), .ALLRED_T(2),
                    .MIN_GREEN(4), .FLASH_T(2), .SKIP_EN(0))
    u_dut_c (.clk(clk), .rst(rst), .bus(ifc));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, %0d entries pending", sb_q.size());
    $fatal(1, "watchdog");
  end

  // Monitor: one scoreboard entry per cycle, sampled mid-cycle.
  initial begin
    exp_t        e;
    logic [11:0] al;
    logic [1:0]  ap;
    logic        aa, af;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        case (e.dut)
          DA: begin al = 12'(ifa.lights); ap = 2'(ifa.cur_phase); aa = ifa.preempt_ack; af = ifa.in_flash; end
          DB: begin al = 12'(ifb.lights); ap = 2'(ifb.cur_phase); aa = ifb.preempt_ack; af = ifb.in_flash; end
          default: begin al = 12'(ifc.lights); ap = 2'(ifc.cur_phase); aa = ifc.preempt_ack; af = ifc.in_flash; end
        endcase
        check(e, al, ap, aa, af);
      end
    end
  end

  task automatic check(input exp_t e, input logic [11:0] al, input logic [1:0] ap,
                       input logic aa, input logic af);
    checks++;
    if ({al, ap, aa, af} !== {e.lights, e.phase, e.ack, e.fl}) begin
      failures++;
      $display("FAIL test%0d dut%0d t=%0t: got lights=%b phase=%0d ack=%b in_flash=%b, want lights=%b phase=%0d ack=%b in_flash=%b",
               e.tag, e.dut, $time, al, ap, aa, af, e.lights, e.phase, e.ack, e.fl);
    end
  endtask

  // Push the expected outputs for n consecutive cycles, starting with the
  // current one; returns at the start (posedge+1) of the following cycle.
  task automatic expect_n(input int dut, input int tag, input int n, input logic [11:0] l,
                          input logic [1:0] p, input logic a, input logic f);
    exp_t e;
    e.dut = dut; e.tag = tag; e.lights = l; e.phase = p; e.ack = a; e.fl = f;
    repeat (n) begin
      sb_q.push_back(e);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle_inputs();
    ifa.req = '0; ifa.preempt = 1'b0; ifa.preempt_dir = '0; ifa.flash = 1'b0;
    ifb.req = '0; ifb.preempt = 1'b0; ifb.preempt_dir = '0; ifb.flash = 1'b0;
    ifc.req = '0; ifc.preempt = 1'b0; ifc.preempt_dir = '0; ifc.flash = 1'b0;
  endtask

  // Leaves rst released at posedge+1, i.e. the first post-reset cycle.
  task automatic do_reset();
    rst = 1'b0;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    idle_inputs();

    // 1: fixed cycle on A, 2 all-red, 8 green, 3 yellow, 2 all-red per phase; period 26.
    do_reset();
    expect_n(DA, 1, 2, {LO, LO, LR, LR}, 2'd1, 1'b0, 1'b0);
    expect_n(DA, 1, 8, {LO, LO, LR, LG}, 2'd0, 1'b0, 1'b0);
    expect_n(DA, 1, 3, {LO, LO, LR, LY}, 2'd0, 1'b0, 1'b0);
    expect_n(DA, 1, 2, {LO, LO, LR, LR}, 2'd0, 1'b0, 1'b0);
    expect_n(DA, 1, 8, {LO, LO, LG, LR}, 2'd1, 1'b0, 1'b0);
    expect_n(DA, 1, 3, {LO, LO, LY, LR}, 2'd1, 1'b0, 1'b0);
    expect_n(DA, 1, 2, {LO, LO, LR, LR}, 2'd1, 1'b0, 1'b0);
    expect_n(DA, 1, 1, {LO, LO, LR, LG}, 2'd0, 1'b0, 1'b0);

    // 2: skipping on B; req[2] pulsed in phase-0 green -> phase 2 next, then
    // phase 3 (phase 2 again would mean dem[2] was not cleared on entry).
    do_reset();
    expect_n(DB, 2, 2, {LR, LR, LR, LR}, 2'd3, 1'b0, 1'b0);
    ifb.req = 4'b0100;
    expect_n(DB, 2, 1, {LR, LR, LR, LG}, 2'd0, 1'b0, 1'b0);
    ifb.req = 4'b0000;
    expect_n(DB, 2, 7, {LR, LR, LR, LG}, 2'd0, 1'b0, 1'b0);
    expect_n(DB, 2, 3, {LR, LR, LR, LY}, 2'd0, 1'b0, 1'b0);
    expect_n(DB, 2, 2, {LR, LR, LR, LR}, 2'd0, 1'b0, 1'b0);
    expect_n(DB, 2, 8, {LR, LG, LR, LR}, 2'd2, 1'b0, 1'b0);
    expect_n(DB, 2, 3, {LR, LY, LR, LR}, 2'd2, 1'b0, 1'b0);
    expect_n(DB, 2, 2, {LR, LR, LR, LR}, 2'd2, 1'b0, 1'b0);
    expect_n(DB, 2, 1, {LG, LR, LR, LR}, 2'd3, 1'b0, 1'b0);

    // 3: preempt dir 1 from phase-0 green t_cnt=1 -> 4 green cycles, then
    // phase 1 held past 8 cycles with ack, yellow one cycle after release.
    do_reset();
    expect_n(DA, 3, 2, {LO, LO, LR, LR}, 2'd1, 1'b0, 1'b0);
    expect_n(DA, 3, 1, {LO, LO, LR, LG}, 2'd0, 1'b0, 1'b0);
    ifa.preempt = 1'b1;
    ifa.preempt_dir = 1'b1;
    expect_n(DA, 3, 3, {LO, LO, LR, LG}, 2'd0, 1'b0, 1'b0);
    expect_n(DA, 3, 3, {LO, LO, LR, LY}, 2'd0, 1'b0, 1'b0);
    expect_n(DA, 3, 2, {LO, LO, LR, LR}, 2'd0, 1'b0, 1'b0);
    expect_n(DA, 3, 12, {LO, LO, LG, LR}, 2'd1, 1'b1, 1'b0);
    ifa.preempt = 1'b0;
    expect_n(DA, 3, 1, {LO, LO, LG, LR}, 2'd1, 1'b0, 1'b0);
    expect_n(DA, 3, 3, {LO, LO, LY, LR}, 2'd1, 1'b0, 1'b0);
    expect_n(DA, 3, 2, {LO, LO, LR, LR}, 2'd1, 1'b0, 1'b0);
    expect_n(DA, 3, 1, {LO, LO, LR, LG}, 2'd0, 1'b0, 1'b0);

    // 4: flash requested mid-green; green/yellow/all-red finish, then blink
    // every 2 cycles starting lit; release -> 2 all-red, then phase 0.
    do_reset();
    expect_n(DA, 4, 2, {LO, LO, LR, LR}, 2'd1, 1'b0, 1'b0);
    expect_n(DA, 4, 2, {LO, LO, LR, LG}, 2'd0, 1'b0, 1'b0);
    ifa.flash = 1'b1;
    expect_n(DA, 4, 6, {LO, LO, LR, LG}, 2'd0, 1'b0, 1'b0);
    expect_n(DA, 4, 3, {LO, LO, LR, LY}, 2'd0, 1'b0, 1'b0);
    expect_n(DA, 4, 2, {LO, LO, LR, LR}, 2'd0, 1'b0, 1'b0);
    expect_n(DA, 4, 2, {LO, LO, LR, LY}, 2'd0, 1'b0, 1'b1);
    expect_n(DA, 4, 2, {LO, LO, LO, LO}, 2'd0, 1'b0, 1'b1);
    expect_n(DA, 4, 2, {LO, LO, LR, LY}, 2'd0, 1'b0, 1'b1);
    ifa.flash = 1'b0;
    expect_n(DA, 4, 1, {LO, LO, LO, LO}, 2'd0, 1'b0, 1'b1);
    expect_n(DA, 4, 2, {LO, LO, LR, LR}, 2'd1, 1'b0, 1'b0);
    expect_n(DA, 4, 1, {LO, LO, LR, LG}, 2'd0, 1'b0, 1'b0);

    // 5: reset mid-yellow on B forces all-red within the same cycle; the
    // demand for phase 3 latched before reset must be gone (phase 0 next).
    do_reset();
    expect_n(DB, 5, 2, {LR, LR, LR, LR}, 2'd3, 1'b0, 1'b0);
    ifb.req = 4'b1000;
    expect_n(DB, 5, 1, {LR, LR, LR, LG}, 2'd0, 1'b0, 1'b0);
    ifb.req = 4'b0000;
    expect_n(DB, 5, 7, {LR, LR, LR, LG}, 2'd0, 1'b0, 1'b0);
    expect_n(DB, 5, 1, {LR, LR, LR, LY}, 2'd0, 1'b0, 1'b0);
    rst = 1'b0;
    expect_n(DB, 5, 2, {LR, LR, LR, LR}, 2'd3, 1'b0, 1'b0);
    rst = 1'b1;
    expect_n(DB, 5, 2, {LR, LR, LR, LR}, 2'd3, 1'b0, 1'b0);
    expect_n(DB, 5, 1, {LR, LR, LR, LG}, 2'd0, 1'b0, 1'b0);

    // 6: preempt with out-of-range dir 3 on C: plain cycling, ack never set.
    do_reset();
    ifc.preempt = 1'b1;
    ifc.preempt_dir = 2'd3;
    expect_n(DC, 6, 2, {LO, LR, LR, LR}, 2'd2, 1'b0, 1'b0);
    expect_n(DC, 6, 8, {LO, LR, LR, LG}, 2'd0, 1'b0, 1'b0);
    expect_n(DC, 6, 3, {LO, LR, LR, LY}, 2'd0, 1'b0, 1'b0);
    expect_n(DC, 6, 2, {LO, LR, LR, LR}, 2'd0, 1'b0, 1'b0);
    expect_n(DC, 6, 8, {LO, LR, LG, LR}, 2'd1, 1'b0, 1'b0);
    expect_n(DC, 6, 3, {LO, LR, LY, LR}, 2'd1, 1'b0, 1'b0);
    expect_n(DC, 6, 2, {LO, LR, LR, LR}, 2'd1, 1'b0, 1'b0);
    expect_n(DC, 6, 1, {LO, LG, LR, LR}, 2'd2, 1'b0, 1'b0);

    @(negedge clk);
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d scoreboard entries never compared, want 0", sb_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
